// File: rtl/datapath_pkg.sv
// Shared opcode encodings, instruction field positions and widths for the datapath.
package datapath_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned REG_N     = 16;
  localparam int unsigned RIDX_W    = 4;
  localparam int unsigned OPC_W     = 5;
  localparam int unsigned MEM_AW    = 9;
  localparam int unsigned MEM_DEPTH = 512;

  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned RA_MSB  = 26;
  localparam int unsigned RB_MSB  = 22;
  localparam int unsigned RC_MSB  = 18;
  localparam int unsigned C_MSB   = 18;

  typedef enum logic [OPC_W-1:0] {
    OP_LD   = 5'b00000,
    OP_LDI  = 5'b00001,
    OP_ST   = 5'b00010,
    OP_ADD  = 5'b00011,
    OP_SUB  = 5'b00100,
    OP_AND  = 5'b00101,
    OP_OR   = 5'b00110,
    OP_SHR  = 5'b00111,
    OP_SHL  = 5'b01000,
    OP_ROR  = 5'b01001,
    OP_ROL  = 5'b01010,
    OP_ADDI = 5'b01011,
    OP_ANDI = 5'b01100,
    OP_ORI  = 5'b01101,
    OP_MUL  = 5'b01110,
    OP_DIV  = 5'b01111,
    OP_NEG  = 5'b10000,
    OP_NOT  = 5'b10001
  } opcode_e;

  // Immediate constant: IR[18:0] sign-extended to the bus width.
  function automatic logic [DATA_W-1:0] imm_c(input logic [DATA_W-1:0] ir);
    return {{(DATA_W-C_MSB-1){ir[C_MSB]}}, ir[C_MSB:0]};
  endfunction

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: A from Y, B from the bus, 64-bit result feeding Z.
module alu
  import datapath_pkg::*;
(
  input  logic [OPC_W-1:0]    opcode,
  input  logic                inc_pc,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic [2*DATA_W-1:0] result_c
);

  logic [4:0]                shamt;
  logic [5:0]                shinv;
  logic signed [2*DATA_W-1:0] a_s;
  logic signed [2*DATA_W-1:0] b_s;
  logic signed [DATA_W-1:0]   quot;
  logic signed [DATA_W-1:0]   rem;

  always_comb begin
    shamt = b[4:0];
    shinv = 6'd32 - {1'b0, shamt};
    a_s   = (2*DATA_W)'(signed'(a));
    b_s   = (2*DATA_W)'(signed'(b));
    quot  = '0;
    rem   = '0;
    // Divide by zero leaves both halves zero.
    if (b != '0) begin
      quot = signed'(a) / signed'(b);
      rem  = signed'(a) % signed'(b);
    end
  end

  always_comb begin
    result_c = '0;
    if (inc_pc) begin
      result_c = {{DATA_W{1'b0}}, b + DATA_W'(1)};
    end else begin
      case (opcode)
        OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI:
                        result_c[DATA_W-1:0] = a + b;
        OP_SUB:         result_c[DATA_W-1:0] = a - b;
        OP_AND, OP_ANDI: result_c[DATA_W-1:0] = a & b;
        OP_OR, OP_ORI:  result_c[DATA_W-1:0] = a | b;
        OP_SHR:         result_c[DATA_W-1:0] = a >> shamt;
        OP_SHL:         result_c[DATA_W-1:0] = a << shamt;
        OP_ROR:         result_c[DATA_W-1:0] = (a >> shamt) | (a << shinv);
        OP_ROL:         result_c[DATA_W-1:0] = (a << shamt) | (a >> shinv);
        OP_MUL:         result_c = a_s * b_s;
        OP_DIV:         result_c = {rem, quot};
        OP_NEG:         result_c[DATA_W-1:0] = DATA_W'(0) - b;
        OP_NOT:         result_c[DATA_W-1:0] = ~b;
        default:        result_c[DATA_W-1:0] = b;
      endcase
    end
  end

endmodule

// File: rtl/datapath_mem.sv
// 512x32 memory: combinational read, synchronous write, contents never reset.
module physical_memory
  import datapath_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [MEM_AW-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_c
);

  logic [DATA_W-1:0] ram_contents [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) ram_contents[addr] <= wdata;
  end

  assign rdata_c = ram_contents[addr];

endmodule

// File: rtl/datapath.sv
// Single-bus 32-bit processor datapath: register file, special registers, ALU, memory.
module datapath
  import datapath_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              PCout,
  input  logic              ZLowout,
  input  logic              ZHighout,
  input  logic              MDRout,
  input  logic              HIout,
  input  logic              LOout,
  input  logic              Cout,
  input  logic              Rout,
  input  logic              BAout,
  input  logic              PCin,
  input  logic              IRin,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Yin,
  input  logic              ZLowIn,
  input  logic              ZHighIn,
  input  logic              HIin,
  input  logic              LOin,
  input  logic              Rin,
  input  logic              RAMin,
  input  logic              InPortIn,
  input  logic              OutPortIn,
  input  logic              IncPC,
  input  logic              Read,
  input  logic              GRA,
  input  logic              GRB,
  input  logic              GRC,
  input  logic [REG_N-1:0]  REGin,
  input  logic [REG_N-1:0]  REGout,
  input  logic [DATA_W-1:0] Mdatain,
  input  logic [DATA_W-1:0] InPort_data,
  output logic [OPC_W-1:0]  opcode,
  output logic [DATA_W-1:0] OutPort_data,
  output logic [DATA_W-1:0] bus
);

  logic [DATA_W-1:0]   r [REG_N];
  logic [DATA_W-1:0]   pc, ir, mar, mdr, y, hi, lo, zhigh, zlow, inport, outport;
  logic [RIDX_W-1:0]   sel;
  logic [REG_N-1:0]    dec, r_in, r_out;
  logic                r_any;
  logic [DATA_W-1:0]   r_bus;
  logic [2*DATA_W-1:0] alu_c;
  logic [DATA_W-1:0]   mem_rd_c;

  // Register-field select and one-hot decode.
  always_comb begin
    sel   = ({RIDX_W{GRA}} & ir[RA_MSB -: RIDX_W])
          | ({RIDX_W{GRB}} & ir[RB_MSB -: RIDX_W])
          | ({RIDX_W{GRC}} & ir[RC_MSB -: RIDX_W]);
    dec   = REG_N'(1) << sel;
    r_in  = (dec & {REG_N{Rin}}) | REGin;
    r_out = (dec & {REG_N{Rout | BAout}}) | REGout;
  end

  // Lowest-numbered driving register wins; R0 reads as zero in base-address mode.
  always_comb begin
    r_any = 1'b0;
    r_bus = '0;
    for (int n = REG_N - 1; n >= 0; n--) begin
      if (r_out[n]) begin
        r_any = 1'b1;
        r_bus = (n == 0 && dec[0] && BAout) ? '0 : r[n];
      end
    end
  end

  always_comb begin
    bus = '0;
    if (r_any)         bus = r_bus;
    else if (HIout)    bus = hi;
    else if (LOout)    bus = lo;
    else if (ZHighout) bus = zhigh;
    else if (ZLowout)  bus = zlow;
    else if (PCout)    bus = pc;
    else if (MDRout)   bus = mdr;
    else if (Cout)     bus = imm_c(ir);
  end

  alu u_alu (
    .opcode   (ir[OPC_MSB -: OPC_W]),
    .inc_pc   (IncPC),
    .a        (y),
    .b        (bus),
    .result_c (alu_c)
  );

  physical_memory physical_memory (
    .clk     (clk),
    .we      (RAMin & clr),
    .addr    (mar[MEM_AW-1:0]),
    .wdata   (mdr),
    .rdata_c (mem_rd_c)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pc      <= '0;
      ir      <= '0;
      mar     <= '0;
      mdr     <= '0;
      y       <= '0;
      hi      <= '0;
      lo      <= '0;
      zhigh   <= '0;
      zlow    <= '0;
      inport  <= '0;
      outport <= '0;
      for (int n = 0; n < REG_N; n++) r[n] <= '0;
    end else begin
      if (PCin)      pc      <= bus;
      if (IRin)      ir      <= bus;
      if (MARin)     mar     <= bus;
      if (MDRin)     mdr     <= Read ? mem_rd_c : Mdatain;
      if (Yin)       y       <= bus;
      if (HIin)      hi      <= bus;
      if (LOin)      lo      <= bus;
      if (ZLowIn)    zlow    <= alu_c[DATA_W-1:0];
      if (ZHighIn)   zhigh   <= alu_c[2*DATA_W-1:DATA_W];
      if (InPortIn)  inport  <= InPort_data;
      if (OutPortIn) outport <= bus;
      for (int n = 0; n < REG_N; n++) begin
        if (r_in[n]) r[n] <= bus;
      end
    end
  end

  assign opcode       = ir[OPC_MSB -: OPC_W];
  assign OutPort_data = outport;

endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath: fetch, immediate load, ALU ops, memory write, async clear.
module tb_datapath;

  logic clk, clr;
  logic PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, Rout, BAout;
  logic PCin, IRin, MARin, MDRin, Yin, ZLowIn, ZHighIn, HIin, LOin, Rin, RAMin, InPortIn, OutPortIn;
  logic IncPC, Read, GRA, GRB, GRC;
  logic [15:0] REGin, REGout;
  logic [31:0] Mdatain, InPort_data;
  logic [4:0]  opcode;
  logic [31:0] OutPort_data, bus;

  int total = 0;
  int bad   = 0;

  datapath dut (
    .clk(clk), .clr(clr),
    .PCout(PCout), .ZLowout(ZLowout), .ZHighout(ZHighout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .Cout(Cout), .Rout(Rout), .BAout(BAout),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin),
    .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .HIin(HIin), .LOin(LOin), .Rin(Rin),
    .RAMin(RAMin), .InPortIn(InPortIn), .OutPortIn(OutPortIn),
    .IncPC(IncPC), .Read(Read), .GRA(GRA), .GRB(GRB), .GRC(GRC),
    .REGin(REGin), .REGout(REGout), .Mdatain(Mdatain), .InPort_data(InPort_data),
    .opcode(opcode), .OutPort_data(OutPort_data), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_all();
    {PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, Rout, BAout} = '0;
    {PCin, IRin, MARin, MDRin, Yin, ZLowIn, ZHighIn, HIin, LOin, Rin, RAMin, InPortIn, OutPortIn} = '0;
    {IncPC, Read, GRA, GRB, GRC} = '0;
    REGin = '0; REGout = '0; Mdatain = '0; InPort_data = '0;
  endtask

  // One clock: strobes set beforehand take effect at the edge, then drop.
  task automatic cyc();
    @(posedge clk);
    #1;
    clear_all();
  endtask

  task automatic load_mdr(input logic [31:0] v);
    Mdatain = v; MDRin = 1'b1; cyc();
  endtask

  task automatic load_reg(input int idx, input logic [31:0] v);
    load_mdr(v);
    MDRout = 1'b1; REGin[idx] = 1'b1; cyc();
  endtask

  task automatic load_ir(input logic [31:0] v);
    load_mdr(v);
    MDRout = 1'b1; IRin = 1'b1; cyc();
  endtask

  task automatic alu_op(input logic [4:0] op, input int ya, input int bb);
    load_ir({op, 27'd0});
    REGout[ya] = 1'b1; Yin = 1'b1; cyc();
    REGout[bb] = 1'b1; ZLowIn = 1'b1; ZHighIn = 1'b1; cyc();
  endtask

  task automatic chk_z(input string tag, input logic [31:0] hi_e, input logic [31:0] lo_e);
    ZLowout = 1'b1; #1;
    chk({tag, "_zlow"}, 64'(bus), 64'(lo_e));
    ZLowout = 1'b0; ZHighout = 1'b1; #1;
    chk({tag, "_zhigh"}, 64'(bus), 64'(hi_e));
    ZHighout = 1'b0;
  endtask

  initial begin
    clear_all();
    clr = 1'b0;
    #2;
    chk("rst_pc", 64'(dut.pc), 64'd0);
    chk("rst_opcode", 64'(opcode), 64'd0);
    chk("rst_bus", 64'(bus), 64'd0);
    chk("rst_outport", 64'(OutPort_data), 64'd0);
    #1 clr = 1'b1;

    // Put the instruction word into ram[0] (MAR is 0); also seed R0 and Y nonzero.
    load_mdr(32'h0080_0075);
    RAMin = 1'b1; MDRout = 1'b1; REGin[0] = 1'b1; Yin = 1'b1; cyc();
    chk("ram0", 64'(dut.physical_memory.ram_contents[0]), 64'h0080_0075);

    // Fetch T0..T2.
    PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1; cyc();
    chk("t0_zlow", 64'(dut.zlow), 64'd1);
    ZLowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; cyc();
    MDRout = 1'b1; IRin = 1'b1; cyc();
    chk("t2_ir", 64'(dut.ir), 64'h0080_0075);
    chk("t2_pc", 64'(dut.pc), 64'd1);
    chk("t2_opcode", 64'(opcode), 64'd0);

    // ldi R1, 117(R0): T3..T5.
    GRB = 1'b1; BAout = 1'b1; Yin = 1'b1; #1;
    chk("t3_bus_r0_base", 64'(bus), 64'd0);
    cyc();
    chk("t3_y", 64'(dut.y), 64'd0);
    Cout = 1'b1; ZHighIn = 1'b1; ZLowIn = 1'b1; cyc();
    chk("t4_zlow", 64'(dut.zlow), 64'd117);
    ZLowout = 1'b1; GRA = 1'b1; Rin = 1'b1; cyc();
    chk("t5_r1", 64'(dut.r[1]), 64'd117);

    // Bus priority: register beats HI; R0 via REGout drives its content.
    REGout[0] = 1'b1; HIout = 1'b1; #1;
    chk("prio_r_over_hi", 64'(bus), 64'h0080_0075);
    clear_all(); MDRout = 1'b1; Cout = 1'b1; #1;
    chk("prio_mdr_over_c", 64'(bus), 64'h0080_0075);
    clear_all(); #1;
    chk("bus_idle", 64'(bus), 64'd0);

    // ALU operations.
    load_reg(2, 32'd5);
    load_reg(3, 32'd7);
    alu_op(5'b00011, 2, 3);  chk_z("add", 32'd0, 32'd12);
    alu_op(5'b00100, 2, 3);  chk_z("sub", 32'd0, 32'hFFFF_FFFE);
    load_reg(4, 32'hFFFF_FFFF);
    load_reg(5, 32'd2);
    alu_op(5'b01110, 4, 5);  chk_z("mul", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    alu_op(5'b01111, 3, 5);  chk_z("div", 32'd1, 32'd3);
    alu_op(5'b01111, 3, 6);  chk_z("div0", 32'd0, 32'd0);
    alu_op(5'b01001, 3, 5);  chk_z("ror", 32'd0, 32'hC000_0001);
    alu_op(5'b01000, 3, 5);  chk_z("shl", 32'd0, 32'd28);
    alu_op(5'b10000, 2, 3);  chk_z("neg", 32'd0, 32'hFFFF_FFF9);

    // Immediate sign extension from bit 18.
    load_ir(32'h0004_0001);
    Cout = 1'b1; #1;
    chk("c_sext", 64'(bus), 64'hFFFC_0001);
    cyc();

    // Memory write at MAR=73 and read-back through MDR.
    load_mdr(32'd73);
    MDRout = 1'b1; MARin = 1'b1; cyc();
    load_mdr(32'hDEAD_BEEF);
    RAMin = 1'b1; cyc();
    chk("ram73", 64'(dut.physical_memory.ram_contents[73]), 64'hDEAD_BEEF);
    load_mdr(32'h0);
    Read = 1'b1; MDRin = 1'b1; cyc();
    MDRout = 1'b1; #1;
    chk("ram73_readback", 64'(bus), 64'hDEAD_BEEF);

    // HI, OutPort and InPort.
    HIin = 1'b1; OutPortIn = 1'b1; cyc();
    chk("outport", 64'(OutPort_data), 64'hDEAD_BEEF);
    HIout = 1'b1; LOout = 1'b1; #1;
    chk("hi_over_lo", 64'(bus), 64'hDEAD_BEEF);
    clear_all();
    InPort_data = 32'h0000_1234; InPortIn = 1'b1; cyc();
    chk("inport", 64'(dut.inport), 64'h1234);

    // Asynchronous clear between edges.
    #2 clr = 1'b0;
    #1;
    chk("clr_pc", 64'(dut.pc), 64'd0);
    chk("clr_ir", 64'(dut.ir), 64'd0);
    chk("clr_mar", 64'(dut.mar), 64'd0);
    chk("clr_mdr", 64'(dut.mdr), 64'd0);
    chk("clr_zlow", 64'(dut.zlow), 64'd0);
    chk("clr_hi", 64'(dut.hi), 64'd0);
    chk("clr_inport", 64'(dut.inport), 64'd0);
    chk("clr_r3", 64'(dut.r[3]), 64'd0);
    chk("clr_outport", 64'(OutPort_data), 64'd0);
    chk("clr_opcode", 64'(opcode), 64'd0);

    // Loads ignored while clear is held across an edge.
    Mdatain = 32'h55; MDRin = 1'b1; InPort_data = 32'h66; InPortIn = 1'b1;
    cyc();
    chk("clr_hold_mdr", 64'(dut.mdr), 64'd0);
    chk("clr_hold_inport", 64'(dut.inport), 64'd0);
    #2 clr = 1'b1;
    load_mdr(32'h77);
    chk("post_clr_mdr", 64'(dut.mdr), 64'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 SHALL connect ports by name; clock and reset are listed first.
REQ-002 SHALL have: clk  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have: clr  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have bus-source strobes (in, 1 each): PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, Rout, BAout.
REQ-005 SHALL have register-load strobes (in, 1 each): PCin, IRin, MARin, MDRin, Yin, ZLowIn, ZHighIn, HIin, LOin, Rin, RAMin, InPortIn, OutPortIn.
REQ-006 SHALL have controls (in, 1 each): IncPC (ALU forced to bus+1), Read (MDR sources memory), GRA, GRB, GRC (IR register-field selects).
REQ-007 SHALL have REGin, REGout  in  16  direct one-hot load/drive enables for R0-R15.
REQ-008 SHALL have Mdatain  in  32  external MDR data when Read=0; InPort_data  in  32  input-port data.
REQ-009 SHALL have opcode  out  5  equal to IR[31:27]; OutPort_data  out  32  output-port register; bus  out  32  current bus value.

Function
REQ-010 SHALL hold 32-bit registers R0-R15, PC, IR, MAR, MDR, Y, HI, LO, InPort, OutPort, and a 64-bit Z (ZHigh/ZLow).
REQ-011 SHALL drive bus from the asserted source; on multiple sources, priority R(decoded)>HI>LO>ZHigh>ZLow>PC>MDR>C; with none asserted, bus=0.
REQ-012 SHALL decode Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15]; the selected field (GRA|GRB|GRC, OR'd) is decoded one-hot.
REQ-013 SHALL load Rn when (decoded & Rin) | REGin bit n; Rn drives bus when (decoded & (Rout|BAout)) | REGout bit n.
REQ-014 SHALL make R0 drive 0 when selected via BAout.
REQ-015 SHALL drive C = IR[18:0] sign-extended from bit 18 when Cout=1.
REQ-016 SHALL load MDR with ram[MAR[8:0]] if Read=1, else Mdatain, on MDRin; a separate bus path to MDR is not provided.
REQ-017 SHALL instantiate memory named physical_memory with array ram_contents, 512x32; combinational read; synchronous write of MDR to ram[MAR[8:0]] on RAMin; contents not reset.
REQ-018 SHALL compute ALU with A=Y, B=bus; IncPC overrides with result bus+1.
REQ-019 SHALL select ALU operation by opcode:
- add for ld 00000, ldi 00001, st 00010, add 00011, addi 01011
- sub 00100; and 00101/andi 01100; or 00110/ori 01101
- shr 00111, shl 01000 (logical, amount B[4:0]); ror 01001, rol 01010
- mul 01110: signed 64-bit product
- div 01111: signed, ZLow=quotient, ZHigh=remainder; divisor 0 gives Z=0
- neg 10000: 0-B; not 10001: ~B; all others: pass B
REQ-020 SHALL give 32-bit ops a result in ZLow with ZHigh=0 (wrap-around, no flags); ZLowIn/ZHighIn load halves independently.
REQ-021 SHALL load HI/LO from bus on HIin/LOin, and OutPort from bus on OutPortIn.
REQ-022 SHALL load InPort from InPort_data on InPortIn; InPort has no bus path.
REQ-023 SHALL resolve simultaneous load and drive of one register by loading the pre-edge bus value.

Reset
REQ-024 SHALL clear all registers (R0-R15, PC, IR, MAR, MDR, Y, Z, HI, LO, InPort, OutPort) to 0 immediately on clr=0, independent of clk; opcode=0.
REQ-025 SHALL ignore all load strobes while clr=0; operation resumes on the first rising edge after release.

Structure
REQ-026 SHALL place opcode encodings and register-field bit positions in a shared package.
REQ-027 SHALL implement the ALU as a single sub-module named alu; memory is physical_memory as specified.

Verification
REQ-028 SHALL cover: ram[0]=0x00800075, PC=0; T0 PCout,MARin,IncPC,ZLowIn; T1 ZLowout,PCin,Read,MDRin; T2 MDRout,IRin -> IR=0x00800075, PC=1, opcode=0.
REQ-029 SHALL cover: continue T3 GRB,BAout,Yin; T4 Cout,ZHighIn,ZLowIn; T5 ZLowout,GRA,Rin -> Y=0, ZLow=117, R1=117.
REQ-030 SHALL cover: add with R2=5, R3=7 (loaded via Mdatain/MDR/REGin) -> ZLow=12; sub 5-7 -> ZLow=0xFFFFFFFE.
REQ-031 SHALL cover: mul Y=0xFFFFFFFF, bus=2 -> Z=0xFFFFFFFF_FFFFFFFE; div 7/2 -> ZLow=3, ZHigh=1.
REQ-032 SHALL cover: MAR=73, MDR=0xDEADBEEF, RAMin -> ram_contents[73]=0xDEADBEEF.
REQ-033 SHALL cover: assert clr=0 mid-sequence between edges -> all registers read 0 before the next edge.
